// File: rtl/logic_unit_seq.sv
// logic_unit_seq: multi-cycle bitwise logic unit, LANE bits per cycle, LSB chunk first.
// Optional ones_cnt output under LOGIC_UNIT_ONES_COUNT_EN.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready high only when idle)
//   a, b, opcode          operands and op (AND OR XOR XNOR NAND NOR NOTA PASSA)
//   out_valid / out_ready result handshake (out_valid high only when done)
//   result, zero, eq      registered result, result==0, a==b
//   ones_cnt              popcount of result (only with LOGIC_UNIT_ONES_COUNT_EN)
module logic_unit_seq #(
  parameter int WIDTH = 8,
  parameter int LANE  = 2
) (
`ifdef LOGIC_UNIT_ONES_COUNT_EN
  output logic [$clog2(WIDTH+1)-1:0] ones_cnt,
`endif
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             eq
);

  localparam int NCHUNK = WIDTH / LANE;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int OW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  generate
    if (WIDTH % LANE != 0) begin : g_bad_lane
      $error("logic_unit_seq: WIDTH must be a multiple of LANE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state;

  logic [NCHUNK-1:0][LANE-1:0] a_r;
  logic [NCHUNK-1:0][LANE-1:0] b_r;
  logic [NCHUNK-1:0][LANE-1:0] res_r;
  logic [2:0]                  op_r;
  logic [CW-1:0]               cnt;
  logic                        eq_acc;
  logic                        zero_acc;
  logic [OW-1:0]               ones_r;

  logic [LANE-1:0] sl;
  logic            sl_eq;
  logic            sl_zero;
  logic [OW-1:0]   sl_pop;

  function automatic logic [LANE-1:0] op_f(
    input logic [2:0]      op,
    input logic [LANE-1:0] x,
    input logic [LANE-1:0] y
  );
    logic [LANE-1:0] r;
    unique case (op)
      3'b000:  r = x & y;
      3'b001:  r = x | y;
      3'b010:  r = x ^ y;
      3'b011:  r = ~(x ^ y);
      3'b100:  r = ~(x & y);
      3'b101:  r = ~(x | y);
      3'b110:  r = ~x;
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic [OW-1:0] pop_f(input logic [LANE-1:0] x);
    logic [OW-1:0] p;
    p = '0;
    for (int i = 0; i < LANE; i++) p = p + OW'(x[i]);
    return p;
  endfunction

  always_comb begin
    sl      = op_f(op_r, a_r[cnt], b_r[cnt]);
    sl_eq   = &(a_r[cnt] ~^ b_r[cnt]);
    sl_zero = ~|sl;
    sl_pop  = pop_f(sl);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= '0;
      res_r     <= '0;
      eq_acc    <= 1'b0;
      zero_acc  <= 1'b0;
      ones_r    <= '0;
      zero      <= 1'b0;
      eq        <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            op_r     <= opcode;
            res_r    <= '0;
            eq_acc   <= 1'b1;
            zero_acc <= 1'b1;
            ones_r   <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          res_r[cnt] <= sl;
          eq_acc     <= eq_acc & sl_eq;
          zero_acc   <= zero_acc & sl_zero;
          ones_r     <= ones_r + sl_pop;
          if (cnt == LAST) begin
            zero      <= zero_acc & sl_zero;
            eq        <= eq_acc & sl_eq;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign result = res_r;

`ifdef LOGIC_UNIT_ONES_COUNT_EN
  assign ones_cnt = ones_r;
`else
  logic unused_ones;
  assign unused_ones = ^ones_r;
`endif

endmodule

// File: tb/tb_logic_unit_seq.sv
// tb_logic_unit_seq: directed + random checks of logic_unit_seq
// against a transaction-level model.
module tb_logic_unit_seq;

  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] opcode = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic       zero;
  logic       eq;
  logic [3:0] ones_cnt;

  logic       v1 = 1'b0;
  logic       rdy1;
  logic [7:0] a1 = '0;
  logic [7:0] b1 = '0;
  logic [2:0] op1 = '0;
  logic       ov1;
  logic [7:0] res1;
  logic       z1;
  logic       e1;
  logic [3:0] ones1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_unit_seq #(.WIDTH(8), .LANE(2)) dut (
`ifdef LOGIC_UNIT_ONES_COUNT_EN
    .ones_cnt (ones_cnt),
`endif
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .eq       (eq)
  );

  logic_unit_seq #(.WIDTH(8), .LANE(8)) dut1 (
`ifdef LOGIC_UNIT_ONES_COUNT_EN
    .ones_cnt (ones1),
`endif
    .clk      (clk),
    .reset    (reset),
    .in_valid (v1),
    .in_ready (rdy1),
    .a        (a1),
    .b        (b1),
    .opcode   (op1),
    .out_valid(ov1),
    .out_ready(1'b1),
    .result   (res1),
    .zero     (z1),
    .eq       (e1)
  );

`ifndef LOGIC_UNIT_ONES_COUNT_EN
  assign ones_cnt = '0;
  assign ones1    = '0;
`endif

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] op,
                                        input logic [7:0] x,
                                        input logic [7:0] y);
    case (op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x ^ y);
      3'd4: return ~(x & y);
      3'd5: return ~(x | y);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  // transaction model: cycles left in flight, done flag, published values
  int         cyc = 0;
  int         m_left = 0;
  bit         m_done = 0;
  logic [7:0] m_res = '0;
  logic       m_zero = 0;
  logic       m_eq = 0;
  int         m_ones = 0;
  logic [7:0] p_res;
  logic       p_zero;
  logic       p_eq;
  int         p_ones;
  int         acc_q[$];

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_left = 0;
      m_done = 0;
      m_res  = '0;
      m_zero = 0;
      m_eq   = 0;
      m_ones = 0;
    end else if (m_done) begin
      if (out_ready) m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1;
        m_res  = p_res;
        m_zero = p_zero;
        m_eq   = p_eq;
        m_ones = p_ones;
      end
    end else if (in_valid) begin
      p_res  = ref_op(opcode, a, b);
      p_zero = (p_res == 8'h00);
      p_eq   = (a == b);
      p_ones = $countones(p_res);
      m_left = NCH;
      acc_q.push_back(cyc);
    end
  end

  always @(posedge clk) begin
    #1;
    chk("in_ready", in_ready, (m_left == 0 && !m_done));
    chk("out_valid", out_valid, m_done);
    if (m_left == 0) begin
      chk("result", result, m_res);
      chk("zero", zero, m_zero);
      chk("eq", eq, m_eq);
`ifdef LOGIC_UNIT_ONES_COUNT_EN
      chk("ones_cnt", ones_cnt, m_ones);
`endif
    end
  end

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_,
                        input logic [2:0] op, input int hold,
                        output logic [7:0] r, output logic z,
                        output logic e, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    in_valid = 1'b1;
    a = ta;
    b = tb_;
    opcode = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    r = result;
    z = zero;
    e = eq;
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, r);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] r;
    logic       z;
    logic       e;
    int         lat;
    int         n;
    int         n0;
    bit         sw;
    logic [7:0] rq[$];

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 8'h00);
    chk("rst_zero", zero, 0);
    chk("rst_eq", eq, 0);

    run_op(8'hA5, 8'h0F, 3'b011, 0, r, z, e, lat);
    chk("xnor_lat", lat, 4);
    chk("xnor_res", r, 8'h55);
    chk("xnor_zero", z, 0);
    chk("xnor_eq", e, 0);
`ifdef LOGIC_UNIT_ONES_COUNT_EN
    chk("xnor_ones", ones_cnt, 4);
`endif

    run_op(8'h3C, 8'h3C, 3'b010, 0, r, z, e, lat);
    chk("xor_res", r, 8'h00);
    chk("xor_zero", z, 1);
    chk("xor_eq", e, 1);

    run_op(8'hFF, 8'h00, 3'b110, 0, r, z, e, lat);
    chk("nota_res", r, 8'h00);
    chk("nota_zero", z, 1);
    chk("nota_eq", e, 0);

    run_op(8'hF0, 8'h3C, 3'b000, 5, r, z, e, lat);
    chk("and_res", r, 8'h30);
    chk("and_lat", lat, 4);

    in_valid = 1'b1;
    a = 8'h12;
    b = 8'h34;
    opcode = 3'b001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 8'h00);
    run_op(8'hC3, 8'h3C, 3'b001, 0, r, z, e, lat);
    chk("postrst_lat", lat, 4);
    chk("postrst_res", r, 8'hFF);

    n0 = acc_q.size();
    sw = 0;
    n = 0;
    a = 8'h00;
    b = 8'h00;
    opcode = 3'b101;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (rq.size() < 2 && n < 60) begin
      @(posedge clk); #1; n++;
      if (acc_q.size() == n0 + 1 && !sw) begin
        a = 8'hFF;
        b = 8'hFF;
        opcode = 3'b100;
        sw = 1;
      end
      if (acc_q.size() >= n0 + 2) in_valid = 1'b0;
      if (out_valid) rq.push_back(result);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_count", rq.size(), 2);
    if (rq.size() >= 2) begin
      chk("b2b_nor", rq[0], 8'hFF);
      chk("b2b_nand", rq[1], 8'h00);
    end
    chk("b2b_accepts", acc_q.size() - n0, 2);
    if (acc_q.size() >= n0 + 2)
      chk("b2b_interval", acc_q[n0+1] - acc_q[n0], 6);

    chk("n1_ready", rdy1, 1);
    a1 = 8'h81;
    b1 = 8'h00;
    op1 = 3'b111;
    v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    chk("n1_busy_valid", ov1, 0);
    @(posedge clk); #1;
    chk("n1_valid", ov1, 1);
    chk("n1_res", res1, 8'h81);
    chk("n1_zero", z1, 0);
    chk("n1_eq", e1, 0);
`ifdef LOGIC_UNIT_ONES_COUNT_EN
    chk("n1_ones", ones1, 2);
`endif

    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      in_valid = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      opcode = 3'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
